// File: rtl/score_row_max.sv
// score_row_max: scales and saturates each incoming dot-product score and
// tracks the running maximum across a row of NUM_KEYS scores. One registered
// stage with valid/ready handshake and full-throughput skid-free flow.

`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 256
`endif

module score_row_max #(
   parameter int W_IN        = 2*`INTEGER_WIDTH + $clog2(`MAX_EMBEDDING_DIM),
   parameter int W_OUT       = 2*`INTEGER_WIDTH,
   parameter int SCALE_SHIFT = 3,
   parameter int NUM_KEYS    = 64,
   localparam int KW         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    vld_in,
   output logic                    rdy_out,
   input  logic signed [W_IN-1:0]  score_in,
   output logic                    vld_out,
   input  logic                    rdy_in,
   output logic signed [W_OUT-1:0] score_out,
   output logic signed [W_OUT-1:0] max_out,
   output logic signed [W_OUT-1:0] max_prev_out,
   output logic [KW-1:0]           key_idx_out,
   output logic                    last_out
);

   // Wide enough to hold any scaled input next to the output bounds.
   localparam int WX = W_IN + W_OUT;
   localparam logic signed [WX-1:0] SAT_MAX = {{(W_IN+1){1'b0}}, {(W_OUT-1){1'b1}}};
   localparam logic signed [WX-1:0] SAT_MIN = {{(W_IN+1){1'b1}}, {(W_OUT-1){1'b0}}};
   localparam logic [KW-1:0]        LAST_IDX = KW'(NUM_KEYS - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [KW-1:0]           r_cnt, w_cnt_nxt;
   logic signed [W_OUT-1:0] r_max, w_max_nxt;

   logic                    w_accept;
   logic signed [WX-1:0]    w_ext;
   logic signed [WX-1:0]    w_shifted;
   logic signed [W_OUT-1:0] w_sat;
   logic signed [W_OUT-1:0] w_prev;
   logic [KW-1:0]           w_idx;
   logic                    w_last;

   assign rdy_out  = rdy_in || !vld_out;
   assign w_accept = vld_in && rdy_out;

   // Scale by arithmetic shift, then clamp into the output range.
   always_comb begin
      w_ext     = WX'(score_in);
      w_shifted = w_ext >>> SCALE_SHIFT;
      if (w_shifted > SAT_MAX)
         w_sat = SAT_MAX[W_OUT-1:0];
      else if (w_shifted < SAT_MIN)
         w_sat = SAT_MIN[W_OUT-1:0];
      else
         w_sat = w_shifted[W_OUT-1:0];
   end

   // Next-state and beat fields; IDLE starts a fresh row ignoring the old max.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx       = '0;
      w_prev      = w_sat;
      w_max_nxt   = w_sat;
      if (r_state == ACTIVE) begin
         w_idx  = r_cnt;
         w_prev = r_max;
         // Ties keep the existing max; the value is identical either way.
         if (r_max >= w_sat)
            w_max_nxt = r_max;
      end
      w_last = (w_idx == LAST_IDX);
      if (w_accept) begin
         if (w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = w_idx + KW'(1);
         end
      end
   end

   // Row-tracking state: changes only on accept, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_max   <= '0;
      end else if (w_accept) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_max   <= w_max_nxt;
      end
   end

   // Output register: load on accept, drop valid when drained, hold on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_out      <= 1'b0;
         score_out    <= '0;
         max_out      <= '0;
         max_prev_out <= '0;
         key_idx_out  <= '0;
         last_out     <= 1'b0;
      end else if (w_accept) begin
         vld_out      <= 1'b1;
         score_out    <= w_sat;
         max_out      <= w_max_nxt;
         max_prev_out <= w_prev;
         key_idx_out  <= w_idx;
         last_out     <= w_last;
      end else if (rdy_in) begin
         vld_out      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_score_row_max.sv
// tb_score_row_max: directed spec scenarios plus randomized traffic, checked
// against a row-queue reference model of the scaling/max rules.

module tb_score_row_max;

   localparam int W_IN  = 24;
   localparam int W_OUT = 16;
   localparam int SS    = 3;
   localparam int NK    = 4;
   localparam int KW    = 2;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    vld_in = 1'b0;
   logic                    rdy_out;
   logic signed [W_IN-1:0]  score_in = '0;
   logic                    vld_out;
   logic                    rdy_in = 1'b1;
   logic signed [W_OUT-1:0] score_out;
   logic signed [W_OUT-1:0] max_out;
   logic signed [W_OUT-1:0] max_prev_out;
   logic [KW-1:0]           key_idx_out;
   logic                    last_out;

   int cmp_cnt = 0;
   int err_cnt = 0;

   // Reference model state: current output beat and the scores of the open row.
   int m_vld, m_score, m_max, m_prev, m_idx, m_last;
   int row[$];

   always #5 clk = ~clk;

   score_row_max #(
      .W_IN(W_IN), .W_OUT(W_OUT), .SCALE_SHIFT(SS), .NUM_KEYS(NK)
   ) dut (
      .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
      .score_in(score_in), .vld_out(vld_out), .rdy_in(rdy_in),
      .score_out(score_out), .max_out(max_out), .max_prev_out(max_prev_out),
      .key_idx_out(key_idx_out), .last_out(last_out)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      cmp_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int scale_sat(input int s);
      int v;
      v = s >>> SS;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return v;
   endfunction

   function automatic int row_max();
      int m;
      m = row[0];
      foreach (row[i]) if (row[i] > m) m = row[i];
      return m;
   endfunction

   // One clock: drive inputs, check combinational ready, advance model, check outputs.
   task automatic cyc(input bit r, input bit v, input int s, input bit rd);
      int sc;
      rst = r; vld_in = v; score_in = W_IN'(s); rdy_in = rd;
      #1;
      chk("rdy_out", rdy_out, (rd || m_vld == 0) ? 1 : 0);
      if (r) begin
         m_vld = 0; m_score = 0; m_max = 0; m_prev = 0; m_idx = 0; m_last = 0;
         row.delete();
      end else if (v && (rd || m_vld == 0)) begin
         sc = scale_sat(s);
         m_prev = (row.size() == 0) ? sc : row_max();
         row.push_back(sc);
         m_score = sc;
         m_max = row_max();
         m_idx = row.size() - 1;
         m_last = (row.size() == NK) ? 1 : 0;
         if (row.size() == NK) row.delete();
         m_vld = 1;
      end else if (rd) begin
         m_vld = 0;
      end
      @(posedge clk);
      #1;
      chk("vld_out", vld_out, m_vld);
      chk("score_out", score_out, m_score);
      chk("max_out", max_out, m_max);
      chk("max_prev_out", max_prev_out, m_prev);
      chk("key_idx_out", key_idx_out, m_idx);
      chk("last_out", last_out, m_last);
   endtask

   int row_in[4]   = '{80, -16, 200, 40};
   int row_sc[4]   = '{10, -2, 25, 5};
   int row_mx[4]   = '{10, 10, 25, 25};
   int row_pv[4]   = '{10, 10, 10, 25};
   int s;

   initial begin
      m_vld = 0; m_score = 0; m_max = 0; m_prev = 0; m_idx = 0; m_last = 0;

      // Reset for two cycles.
      cyc(1, 1, 80, 1);
      cyc(1, 1, 80, 1);
      chk("rst_vld", vld_out, 0);
      chk("rst_score", score_out, 0);
      chk("rst_max", max_out, 0);
      chk("rst_rdy", rdy_out, 1);

      // Full row followed immediately by the next row's first beat.
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, row_in[i], 1);
         chk("row_score", score_out, row_sc[i]);
         chk("row_max", max_out, row_mx[i]);
         chk("row_prev", max_prev_out, row_pv[i]);
         chk("row_idx", key_idx_out, i);
         chk("row_last", last_out, (i == 3) ? 1 : 0);
      end
      cyc(0, 1, -56, 1);
      chk("bnd_idx", key_idx_out, 0);
      chk("bnd_score", score_out, -7);
      chk("bnd_max", max_out, -7);
      chk("bnd_last", last_out, 0);
      chk("bnd_vld", vld_out, 1);
      cyc(0, 0, 0, 1);

      // Saturation at both bounds.
      cyc(0, 1, 4194304, 1);
      chk("sat_hi", score_out, 32767);
      cyc(0, 1, -8388608, 1);
      chk("sat_lo", score_out, -32768);

      // Backpressure: three stalled cycles, then accept on ready return.
      cyc(0, 1, 16, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 800 + i, 0);
         chk("bp_hold", score_out, 2);
         chk("bp_rdy", rdy_out, 0);
      end
      cyc(0, 1, 800, 1);
      chk("bp_accept", score_out, 100);

      // Reset in the middle of a row.
      cyc(1, 0, 0, 1);
      cyc(0, 1, 80, 1);
      cyc(0, 1, 200, 1);
      cyc(1, 1, 400, 1);
      cyc(0, 1, -24, 1);
      chk("mrst_idx", key_idx_out, 0);
      chk("mrst_score", score_out, -3);
      chk("mrst_prev", max_prev_out, -3);
      chk("mrst_max", max_out, -3);

      // Randomized traffic including stalls, resets and extreme scores.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0)
            s = ($urandom_range(0, 1) == 1) ? 8388607 : -8388608;
         else if ($urandom_range(0, 1) == 1)
            s = int'($urandom_range(0, 16777215)) - 8388608;
         else
            s = int'($urandom_range(0, 1023)) - 512;
         cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), s,
             ($urandom_range(0, 9) < 7));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
